decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// Instruction decode stage: register file with write-back bypass,
// main control decode and the ID/EX pipeline register.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] id_instr,
    input  logic [DATA_W-1:0] id_npc,
    input  logic              hold,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] ex_npc,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [1:0]        ex_wb,
    output logic [2:0]        ex_m,
    output logic [3:0]        ex_ex
);

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              wr_en;
    ctrl_t             ctrl;

    logic [DATA_W-1:0] rf [REG_N];

    assign opcode  = id_instr[31:26];
    assign rs      = id_instr[25:21];
    assign rt      = id_instr[20:16];
    assign rd      = id_instr[15:11];
    assign imm_ext = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};

    // Indices past REG_N behave like $zero: never written, read as 0.
    assign wr_en = wb_we && (wb_addr != 5'd0) && (int'(wb_addr) < REG_N);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_N; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Write-back in the same cycle wins over the stored value.
    always_comb begin
        rs_val = '0;
        if (rs != 5'd0 && int'(rs) < REG_N) begin
            if (wr_en && wb_addr == rs) begin
                rs_val = wb_data;
            end else begin
                rs_val = rf[rs];
            end
        end
    end

    always_comb begin
        rt_val = '0;
        if (rt != 5'd0 && int'(rt) < REG_N) begin
            if (wr_en && wb_addr == rt) begin
                rt_val = wb_data;
            end else begin
                rt_val = rf[rt];
            end
        end
    end

    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            opcode == OP_RTYPE: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = 2'b10;
            end
            opcode == OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
            end
            opcode == OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            opcode == OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = 2'b01;
            end
            default: ctrl = '0;
        endcase
    end

    // Flush still captures the data fields; only the control bits bubble.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_npc <= '0;
            ex_rd1 <= '0;
            ex_rd2 <= '0;
            ex_imm <= '0;
            ex_rt  <= '0;
            ex_rd  <= '0;
            ex_wb  <= '0;
            ex_m   <= '0;
            ex_ex  <= '0;
        end else if (flush || !hold) begin
            ex_npc <= id_npc;
            ex_rd1 <= rs_val;
            ex_rd2 <= rt_val;
            ex_imm <= imm_ext;
            ex_rt  <= rt;
            ex_rd  <= rd;
            if (flush) begin
                ex_wb <= '0;
                ex_m  <= '0;
                ex_ex <= '0;
            end else begin
                ex_wb <= {ctrl.reg_write, ctrl.mem_to_reg};
                ex_m  <= {ctrl.branch, ctrl.mem_read, ctrl.mem_write};
                ex_ex <= {ctrl.reg_dst, ctrl.alu_op, ctrl.alu_src};
            end
        end
    end

endmodule
